// File: rtl/audio_pkg.sv
// Shared definitions for the stereo sample path: default sample width,
// pairing FSM states and the packed layout of one stored left/right pair.
package audio_pkg;

  localparam int SAMPLE_W = 20;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } pair_state_t;

  typedef struct packed {
    logic                block_start;
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose read data is the head entry itself, so the consumer
// sees data as soon as the FIFO is non-empty. A write while full is accepted
// only when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap at DEPTH-1 back to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // Occupancy tracks accepted writes and reads; simultaneous ones cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stereo_sample_buffer.sv
// Pairs A/left and B/right samples from the frame dismantler into
// {block_start, left, right} entries and queues them in a fall-through FIFO.
//
//   state  | meaning
//   WAIT_A | expecting a left sample; a right sample here is an orphan
//   WAIT_B | holding a pending left; a right sample completes the pair
//
// The first clock edge after reset release ignores vin so a sample that is
// already on the bus when reset drops is never half-captured.
module stereo_sample_buffer import audio_pkg::*; #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SAMPLE_W-1:0]        din,
  input  logic                       vin,
  input  logic                       channel,
  input  logic                       done,
  input  logic                       kill,
  output logic [SAMPLE_W-1:0]        dout_left,
  output logic [SAMPLE_W-1:0]        dout_right,
  output logic                       dout_block_start,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sync_err,
  output logic                       overflow
);

  localparam int ENTRY_W = 2*SAMPLE_W + 1;

  pair_state_t         state_q;
  pair_state_t         state_d;
  logic [SAMPLE_W-1:0] pending_left_q;
  logic                block_flag_q;
  logic                rst_hold_q;
  logic                sync_err_q;
  logic                overflow_q;
  logic                vin_ok;
  logic                push;
  logic                latch_left;
  logic                pair_err;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;

  assign vin_ok = vin & ~rst_hold_q;

  // Marks the first edge after reset release so vin is ignored there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_hold_q <= 1'b1;
    else     rst_hold_q <= 1'b0;
  end

  // Pairing FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_A;
    else     state_q <= state_d;
  end

  // Next state plus push/latch/error decode; kill overrides any sample.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    latch_left = 1'b0;
    pair_err   = 1'b0;
    if (kill) begin
      state_d = WAIT_A;
    end else if (vin_ok) begin
      case (state_q)
        WAIT_A: begin
          if (channel) begin
            pair_err = 1'b1;
          end else begin
            latch_left = 1'b1;
            state_d    = WAIT_B;
          end
        end
        WAIT_B: begin
          if (channel) begin
            push    = 1'b1;
            state_d = WAIT_A;
          end else begin
            latch_left = 1'b1;
            pair_err   = 1'b1;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Pending left sample; a repeated A overwrites, kill discards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pending_left_q <= '0;
    else if (kill)       pending_left_q <= '0;
    else if (latch_left) pending_left_q <= din;
  end

  // Block-start flag: done or kill arms it, any push attempt consumes it.
  // The pushed entry samples the flag before this update takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                block_flag_q <= 1'b1;
    else if (kill || done)  block_flag_q <= 1'b1;
    else if (push)          block_flag_q <= 1'b0;
  end

  // One-cycle sync error pulse and sticky overflow on a dropped pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_err_q <= pair_err;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign wr_entry = {block_flag_q, pending_left_q, din};
  assign pop      = dout_valid & dout_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (dout_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign dout_valid = ~fifo_empty;
  assign {dout_block_start, dout_left, dout_right} = dout_valid ? rd_entry : '0;
  assign sync_err = sync_err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stereo_sample_buffer.sv
// Directed bench for stereo_sample_buffer: inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge of interest.
module tb_stereo_sample_buffer;

  logic        clk;
  logic        rst;
  logic [19:0] din;
  logic        vin;
  logic        channel;
  logic        done;
  logic        kill;
  logic [19:0] dout_left;
  logic [19:0] dout_right;
  logic        dout_block_start;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  count;
  logic        sync_err;
  logic        overflow;

  int checks = 0;
  int fails  = 0;

  stereo_sample_buffer #(.SAMPLE_W(20), .DEPTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .din              (din),
    .vin              (vin),
    .channel          (channel),
    .done             (done),
    .kill             (kill),
    .dout_left        (dout_left),
    .dout_right       (dout_right),
    .dout_block_start (dout_block_start),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .count            (count),
    .sync_err         (sync_err),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic ch, input logic [19:0] d);
    @(negedge clk); vin = 1'b1; channel = ch; din = d;
    @(negedge clk); vin = 1'b0; channel = 1'b0; din = '0;
  endtask

  task automatic pop_one();
    @(negedge clk); dout_ready = 1'b1;
    @(negedge clk); dout_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; channel = 1'b0; din = '0;
    done = 1'b0; kill = 1'b0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if ({dout_block_start, dout_left, dout_right} !== 41'd0) begin fails++; $display("FAIL reset_dout got %h want 0", {dout_block_start, dout_left, dout_right}); end
    checks++; if ({sync_err, overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {sync_err, overflow}); end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    rst = 1'b0; vin = 1'b1; channel = 1'b0; din = 20'h77777;
    @(negedge clk); vin = 1'b0; din = '0;
    send(1'b1, 20'h88888);
    checks++; if (sync_err !== 1'b1) begin fails++; $display("FAIL release_ignore_a sync_err got %b want 1", sync_err); end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL release_count got %0d want 0", count); end
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    send(1'b0, 20'h12345);
    send(1'b1, 20'hABCDE);
    checks++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", dout_valid); end
    checks++; if (dout_left !== 20'h12345) begin fails++; $display("FAIL basic_left got %h want 12345", dout_left); end
    checks++; if (dout_right !== 20'hABCDE) begin fails++; $display("FAIL basic_right got %h want abcde", dout_right); end
    checks++; if (dout_block_start !== 1'b1) begin fails++; $display("FAIL basic_bs got %b want 1", dout_block_start); end
    checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL basic_sync_err got %b want 0", sync_err); end
    @(negedge clk);
    dout_ready = 1'b0;
    checks++; if ({dout_valid, count} !== 5'd0) begin fails++; $display("FAIL basic_drained got %b/%0d want 0/0", dout_valid, count); end
  endtask

  task automatic test_misorder();
    int errs = 0;
    send(1'b1, 20'h0B001); if (sync_err) errs++;
    send(1'b0, 20'h0A001); if (sync_err) errs++;
    send(1'b0, 20'h0A002); if (sync_err) errs++;
    send(1'b1, 20'h0B002); if (sync_err) errs++;
    checks++; if (errs != 2) begin fails++; $display("FAIL misorder_errs got %0d want 2", errs); end
    checks++; if (count !== 4'd1) begin fails++; $display("FAIL misorder_count got %0d want 1", count); end
    checks++; if ({dout_block_start, dout_left, dout_right} !== {1'b0, 20'h0A002, 20'h0B002}) begin
      fails++; $display("FAIL misorder_entry got %b/%h/%h want 0/0a002/0b002", dout_block_start, dout_left, dout_right);
    end
    pop_one();
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL misorder_drain got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      send(1'b0, 20'h00100 + 20'(i));
      send(1'b1, 20'h00200 + 20'(i));
      if (i == 8) begin
        checks++; if ({count, overflow} !== {4'd8, 1'b0}) begin fails++; $display("FAIL ovf_at8 got %0d/%b want 8/0", count, overflow); end
      end
    end
    checks++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", count); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if ({dout_valid, dout_left, dout_right} !== {1'b1, 20'h00100 + 20'(i), 20'h00200 + 20'(i)}) begin
        fails++; $display("FAIL ovf_drain%0d got %b/%h/%h want 1/%h/%h", i, dout_valid, dout_left, dout_right, 20'h00100 + 20'(i), 20'h00200 + 20'(i));
      end
      pop_one();
    end
    checks++; if ({dout_valid, count} !== 5'd0) begin fails++; $display("FAIL ovf_empty got %b/%0d want 0/0", dout_valid, count); end
  endtask

  task automatic test_done();
    logic [2:0]  bs_exp;
    logic [19:0] left_exp [3];
    bs_exp = 3'b101;
    left_exp[0] = 20'h00001; left_exp[1] = 20'h00003; left_exp[2] = 20'h00005;
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    send(1'b0, 20'h00001); send(1'b1, 20'h00002);
    send(1'b0, 20'h00003);
    @(negedge clk); vin = 1'b1; channel = 1'b1; din = 20'h00004; done = 1'b1;
    @(negedge clk); vin = 1'b0; channel = 1'b0; din = '0; done = 1'b0;
    send(1'b0, 20'h00005); send(1'b1, 20'h00006);
    checks++; if (count !== 4'd3) begin fails++; $display("FAIL done_count got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dout_block_start, dout_left} !== {bs_exp[2-i], left_exp[i]}) begin
        fails++; $display("FAIL done_entry%0d got %b/%h want %b/%h", i, dout_block_start, dout_left, bs_exp[2-i], left_exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_kill();
    logic [2:0]  bs_exp;
    logic [19:0] left_exp [3];
    logic [19:0] right_exp [3];
    bs_exp = 3'b101;
    left_exp[0]  = 20'h0AAA1; left_exp[1]  = 20'h0AAA2; left_exp[2]  = 20'h33333;
    right_exp[0] = 20'h0BBB1; right_exp[1] = 20'h0BBB2; right_exp[2] = 20'h44444;
    apply_reset();
    send(1'b0, 20'h0AAA1); send(1'b1, 20'h0BBB1);
    send(1'b0, 20'h0AAA2); send(1'b1, 20'h0BBB2);
    send(1'b0, 20'h11111);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    send(1'b1, 20'h22222);
    checks++; if (sync_err !== 1'b1) begin fails++; $display("FAIL kill_orphan_b got %b want 1", sync_err); end
    send(1'b0, 20'h33333); send(1'b1, 20'h44444);
    checks++; if (count !== 4'd3) begin fails++; $display("FAIL kill_count got %0d want 3", count); end
    @(negedge clk); vin = 1'b1; channel = 1'b0; din = 20'h55555; kill = 1'b1;
    @(negedge clk); vin = 1'b0; din = '0; kill = 1'b0;
    send(1'b1, 20'h66666);
    checks++; if ({sync_err, count} !== {1'b1, 4'd3}) begin fails++; $display("FAIL kill_priority got %b/%0d want 1/3", sync_err, count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dout_block_start, dout_left, dout_right} !== {bs_exp[2-i], left_exp[i], right_exp[i]}) begin
        fails++; $display("FAIL kill_entry%0d got %b/%h/%h want %b/%h/%h", i, dout_block_start, dout_left, dout_right, bs_exp[2-i], left_exp[i], right_exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 20'h00300 + 20'(i));
      send(1'b1, 20'h00380 + 20'(i));
    end
    checks++; if (count !== 4'd8) begin fails++; $display("FAIL fullpp_fill got %0d want 8", count); end
    send(1'b0, 20'h003F0);
    @(negedge clk); vin = 1'b1; channel = 1'b1; din = 20'h003F8; dout_ready = 1'b1;
    @(negedge clk); vin = 1'b0; channel = 1'b0; din = '0; dout_ready = 1'b0;
    checks++; if ({count, overflow} !== {4'd8, 1'b0}) begin fails++; $display("FAIL fullpp_count got %0d/%b want 8/0", count, overflow); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (dout_left !== 20'h00300 + 20'(i)) begin fails++; $display("FAIL fullpp_drain%0d got %h want %h", i, dout_left, 20'h00300 + 20'(i)); end
      pop_one();
    end
    checks++; if ({dout_left, dout_right} !== {20'h003F0, 20'h003F8}) begin fails++; $display("FAIL fullpp_last got %h/%h want 003f0/003f8", dout_left, dout_right); end
    pop_one();
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL fullpp_empty got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 20'h00500 + 20'(i));
      send(1'b1, 20'h00580 + 20'(i));
    end
    checks++; if (count !== 4'd3) begin fails++; $display("FAIL arst_pre got %0d want 3", count); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({count, dout_valid} !== 5'd0) begin fails++; $display("FAIL arst_async got %0d/%b want 0/0", count, dout_valid); end
    checks++; if ({dout_block_start, dout_left, dout_right} !== 41'd0) begin fails++; $display("FAIL arst_dout got %h want 0", {dout_block_start, dout_left, dout_right}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({count, dout_valid} !== 5'd0) begin fails++; $display("FAIL arst_after got %0d/%b want 0/0", count, dout_valid); end
  endtask

  initial begin
    rst = 1'b1; din = '0; vin = 1'b0; channel = 1'b0;
    done = 1'b0; kill = 1'b0; dout_ready = 1'b0;
    test_reset();
    test_reset_release();
    test_basic();
    test_misorder();
    test_overflow();
    test_done();
    test_kill();
    test_full_push_pop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stereo_sample_buffer.md
STEREO_SAMPLE_BUFFER -- requirements
Module: stereo_sample_buffer

Interface
REQ-001 Parameter SAMPLE_W, default 20, SHALL set the audio sample width.
REQ-002 Parameter DEPTH, default 8 (power of two), SHALL set the number of pair entries in the FIFO.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din  input  SAMPLE_W  audio sample from the frame dismantler.
REQ-006 vin  input  1  din valid, one-cycle strobe per sample.
REQ-007 channel  input  1  subframe tag for din: 0 = A/left, 1 = B/right.
REQ-008 done  input  1  one-cycle pulse marking the end of a 192-frame block.
REQ-009 kill  input  1  one-cycle pulse signalling loss of frame lock.
REQ-010 dout_left  output  SAMPLE_W  head-entry left sample.
REQ-011 dout_right  output  SAMPLE_W  head-entry right sample.
REQ-012 dout_block_start  output  1  head entry is the first pair of a block.
REQ-013 dout_valid  output  1  FIFO non-empty.
REQ-014 dout_ready  input  1  consumer accepts the head entry.
REQ-015 count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-016 sync_err  output  1  one-cycle pulse on a misordered or dropped sample.
REQ-017 overflow  output  1  sticky; a completed pair was dropped because the FIFO was full.

Function
REQ-018 The pairing FSM SHALL have two states: WAIT_A (reset state) and WAIT_B.
REQ-019 In WAIT_A, vin with channel=0 SHALL latch din as pending-left and move to WAIT_B.
REQ-020 In WAIT_A, vin with channel=1 SHALL discard din, pulse sync_err the next cycle, and stay in WAIT_A.
REQ-021 In WAIT_B, vin with channel=1 SHALL push {block_flag, pending-left, din} into the FIFO and return to WAIT_A.
REQ-022 In WAIT_B, vin with channel=0 SHALL overwrite pending-left, pulse sync_err, and stay in WAIT_B.
REQ-023 block_flag SHALL be set by done and cleared by any push attempt, accepted or dropped; the pushed entry carries the flag value held before clearing.
REQ-024 kill SHALL discard pending-left, force WAIT_A, and set block_flag; FIFO contents SHALL be retained.
REQ-025 kill SHALL take priority over vin and done in the same cycle.
REQ-026 When done and vin occur in the same cycle, the vin action SHALL use the old flag, and the flag SHALL end the cycle set.
REQ-027 Output SHALL be first-word-fall-through; a pushed pair SHALL be visible on the outputs with dout_valid=1 one cycle after the B-sample vin.
REQ-028 A pop SHALL occur when dout_valid and dout_ready are both 1.
REQ-029 dout_* SHALL hold the head entry stable while dout_valid=1 and dout_ready=0.
REQ-030 A push while full SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle, in which case both SHALL succeed.
REQ-031 A push and a pop in the same cycle while empty SHALL be impossible, because of FWFT latency; count SHALL then increment.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-033 dout_ready while empty SHALL have no effect.

Reset
REQ-034 rst SHALL immediately clear: FSM to WAIT_A, pending-left to 0, block_flag to 1, pointers to 0, count to 0, dout_valid to 0, dout_left/right/block_start to 0, sync_err to 0, overflow to 0.
REQ-035 rst asserted mid-pair or mid-transfer SHALL discard all buffered data.
REQ-036 No vin SHALL be accepted in the cycle rst deasserts.

Structure
REQ-037 A shared package audio_pkg SHALL hold SAMPLE_W, the FSM state enum, and the pair-entry struct {block_start, left, right}.
REQ-038 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width and DEPTH, exposing full, empty and count.

Verification
REQ-039 Send A=0x12345 then B=0xABCDE, with dout_ready=1: one entry left=0x12345, right=0xABCDE, block_start=1, valid one cycle after B.
REQ-040 Send B, A, A, B with no done pulse: sync_err pulses twice; one pair is stored, left = second A.
REQ-041 Hold dout_ready=0 and send 9 pairs: count=8, overflow=1 after the 9th pair, and pairs 1-8 drain in order.
REQ-042 Send A, then kill, then B, then A, B: sync_err pulses on the orphan B; one pair is stored with block_start=1; the FIFO entry that preceded kill is intact.
REQ-043 With DEPTH=8, drive a full FIFO with push and pop in the same cycle: no overflow, and count stays 8.
REQ-044 Assert rst with 3 entries queued: count=0, dout_valid=0 asynchronously, before the next clk edge.
